sgpr_rd_port_arbiter: RTL and testbench
=======================================

Name: sgpr_rd_port_arbiter

Overview:
- Read-side counterpart of the SGPR write-port select/mux path.
- Accepts read requests from up to NUM_PORTS clients (SALU, SIMD/SIMF operand fetch, LSU) and grants one per cycle, round-robin.
- Drives the single SGPR bank read port and routes returned data back to the granted client through a fixed-latency tag pipeline.
- Also emits a one-hot read-port select, encoded exactly like the write-side select, for debug and trace.

Parameters:
- NUM_PORTS, 10, number of read clients (max 16).
- RD_LATENCY, 1, cycles from bank_rd_en to valid bank_rd_data (1..4).
- ADDR_W, 9, SGPR quad address width.
- DATA_W, 128, read data width (4 x 32-bit dwords).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  NUM_PORTS  per-client read request; held until acked.
- req_addr  in  NUM_PORTS*ADDR_W  per-client address; client i owns slice [i*ADDR_W +: ADDR_W].
- req_en  in  NUM_PORTS*4  per-client dword enables; slice [i*4 +: 4].
- req_ack  out  NUM_PORTS  one-hot grant, combinational, same cycle as acceptance.
- rd_stall  in  1  bank busy with a write; blocks new grants only.
- bank_rd_en  out  4  registered dword read enables to the SGPR bank.
- bank_rd_addr  out  ADDR_W  registered read address.
- bank_rd_data  in  DATA_W  bank read data.
- rd_port_select  out  16  registered one-hot of the issuing client, aligned with bank_rd_en; all zeros when idle.
- rsp_vld  out  NUM_PORTS  one-hot response strobe.
- rsp_data  out  DATA_W  registered response data, shared by all clients.

Behaviour:
- Reset (async, immediate): rr_ptr=0, tag pipeline cleared. bank_rd_en, bank_rd_addr, rd_port_select, rsp_vld and rsp_data are all 0.
- Arbitration (combinational):
  - If rd_stall=1 or req_vld=0, req_ack=0.
  - Otherwise grant the first set req_vld bit searching upward from rr_ptr with wrap at NUM_PORTS-1 to 0.
  - Exactly one grant per cycle.
- Acceptance: req_vld[i] & req_ack[i] at a clock edge. After that edge rr_ptr = (i+1) mod NUM_PORTS. rr_ptr is unchanged when nothing is granted.
- Issue, cycle t+1 after acceptance in cycle t:
  - bank_rd_en = req_en slice of i.
  - bank_rd_addr = req_addr slice of i.
  - rd_port_select = 1<<i.
  - With no acceptance, all three are 0 in the next cycle. Address is 0, not held.
- Tag pipeline: RD_LATENCY-deep shift of {valid, one-hot id}, loaded at issue.
- Response:
  - bank_rd_data is sampled at the end of cycle t+1+RD_LATENCY.
  - In cycle t+2+RD_LATENCY: rsp_vld = 1<<i and rsp_data = the sampled data.
  - rsp_vld is a single-cycle pulse. rsp_data holds its value until the next response.
  - Total latency from acceptance to response is RD_LATENCY+2 cycles (3 at default).
- Throughput: one accept per cycle, fully pipelined. Back-to-back grants produce back-to-back responses in grant order.
- req_en=0 request: granted and tracked normally. bank_rd_en=0, rsp_vld still pulses, rsp_data is don't-care.
- rd_stall: blocks new grants only. In-flight tags continue and their responses are delivered.
- Same client re-requesting: allowed the cycle after its ack. It is served again only after other pending clients, per round-robin.
- Request drop: a client dropping req_vld before ack is legal. No state is retained.
- Reset mid-operation: in-flight tags are discarded, no response is emitted for them, rr_ptr returns to 0.
- Ports NUM_PORTS..15 of rd_port_select are tied 0.

Decomposition:
- Shared package sgpr_pkg: SGPR_ADDR_W=9, SGPR_DATA_W=128, SGPR_DW_PER_QUAD=4, port-index constants (SALU port = 9, etc.) shared with the write mux.
- Sub-module rr_arbiter (NUM_PORTS param):
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and its binary index.
  - Reusable by the write-side select generator.

Test Plan:
- Single read: req_vld[3]=1, addr=9'h012, en=4'hF, bank returns 128'hA5.. one cycle after bank_rd_en -> req_ack=10'h008 in cycle 0; cycle 1 bank_rd_addr=9'h012, rd_port_select=16'h0008; cycle 3 rsp_vld=10'h008, rsp_data=128'hA5...
- All ten requesting continuously from reset -> grants 0,1,...,9,0 on consecutive cycles; responses in the same order, one per cycle, each with the matching data.
- rr_ptr=5, requests on ports 2 and 7 -> port 7 granted first, then port 2.
- rd_stall=1 for 3 cycles with port 9 (SALU) requesting and one read in flight -> in-flight response still delivered; port 9 acked the first cycle rd_stall=0.
- Reset asserted the cycle after bank_rd_en -> all outputs 0 asynchronously; no rsp_vld after reset release; the next grant starts at port 0.
- RD_LATENCY=3 build with req_en=4'b0101 on port 1 -> bank_rd_en=4'b0101; rsp_vld[1] exactly 5 cycles after the ack.

Source files
------------

// File: rtl/sgpr_pkg.sv
// Shared SGPR constants and types used by the read-port arbiter and the
// write-port select/mux path.
package sgpr_pkg;

  localparam int SGPR_ADDR_W      = 9;
  localparam int SGPR_DATA_W      = 128;
  localparam int SGPR_DW_PER_QUAD = 4;
  localparam int SGPR_MAX_PORTS   = 16;
  localparam int SGPR_PORT_IDX_W  = 4;

  // Client port indices. These match the write-side select encoding, so a
  // one-hot select bit means the same client on both sides.
  typedef enum logic [SGPR_PORT_IDX_W-1:0] {
    SGPR_PORT_SIMD0 = 4'd0,
    SGPR_PORT_SIMD1 = 4'd1,
    SGPR_PORT_SIMD2 = 4'd2,
    SGPR_PORT_SIMD3 = 4'd3,
    SGPR_PORT_SIMF0 = 4'd4,
    SGPR_PORT_SIMF1 = 4'd5,
    SGPR_PORT_SIMF2 = 4'd6,
    SGPR_PORT_SIMF3 = 4'd7,
    SGPR_PORT_LSU   = 4'd8,
    SGPR_PORT_SALU  = 4'd9
  } sgpr_port_e;

  localparam int SGPR_SALU_PORT = 9;
  localparam int SGPR_LSU_PORT  = 8;

  // One-hot select word for a port index, as used on the select/trace buses.
  function automatic logic [SGPR_MAX_PORTS-1:0] sgpr_port_onehot(
    input logic [SGPR_PORT_IDX_W-1:0] idx
  );
    logic [SGPR_MAX_PORTS-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// above ptr, wrapping from NUM_PORTS-1 back to 0. Shared with the
// write-side select generator.
module rr_arbiter
  import sgpr_pkg::*;
#(
  parameter int NUM_PORTS = 10,
  parameter int IDX_W     = SGPR_PORT_IDX_W
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  input  logic                 enable,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_vld
);

  // Scan NUM_PORTS candidates starting at ptr; the first hit wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (enable) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NUM_PORTS) begin
          cand = cand - NUM_PORTS;
        end
        cand_idx = IDX_W'(cand);
        if (!grant_vld && req[cand_idx]) begin
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
          grant_vld       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sgpr_rd_port_arbiter.sv
// SGPR bank read-port arbiter. Grants one client per cycle round-robin,
// issues the read to the bank one cycle later, and routes the returned data
// back to the issuing client after a fixed-latency tag pipeline.
//
// Handshake: req_vld[i]/req_ack[i] follow valid/ready rules. A request
// transfers on a rising clk edge where both are high. The client keeps
// req_vld, its address slice and its enable slice stable until that edge; it
// may also withdraw the request before it is acked, and nothing about the
// withdrawn request is remembered. req_ack is combinational and never
// depends on the same cycle's rd_stall being low late in the cycle only --
// rd_stall=1 forces req_ack to zero for the whole cycle.
module sgpr_rd_port_arbiter
  import sgpr_pkg::*;
#(
  parameter int NUM_PORTS  = 10,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = SGPR_ADDR_W,
  parameter int DATA_W     = SGPR_DATA_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  req_vld,
  input  logic [NUM_PORTS*ADDR_W-1:0]           req_addr,
  input  logic [NUM_PORTS*SGPR_DW_PER_QUAD-1:0] req_en,
  output logic [NUM_PORTS-1:0]                  req_ack,
  input  logic                                  rd_stall,
  output logic [SGPR_DW_PER_QUAD-1:0]           bank_rd_en,
  output logic [ADDR_W-1:0]                     bank_rd_addr,
  input  logic [DATA_W-1:0]                     bank_rd_data,
  output logic [SGPR_MAX_PORTS-1:0]             rd_port_select,
  output logic [NUM_PORTS-1:0]                  rsp_vld,
  output logic [DATA_W-1:0]                     rsp_data
);

  localparam int IDX_W = SGPR_PORT_IDX_W;
  localparam int EN_W  = SGPR_DW_PER_QUAD;

  // Round-robin pointer: the port searched first in the next cycle.
  logic [IDX_W-1:0]     rr_ptr;

  // Arbiter outputs for the current cycle.
  logic                 arb_enable;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_vld;

  // Address/enable of the granted client, zero when nothing is granted.
  logic [EN_W-1:0]      sel_en;
  logic [ADDR_W-1:0]    sel_addr;

  // The issue stage identity is carried by rd_port_select itself.
  logic [NUM_PORTS-1:0] issue_id;
  logic                 issue_vld;

  // Tag pipeline: stage k holds the read issued k+1 cycles ago.
  logic [RD_LATENCY-1:0] tag_vld;
  logic [NUM_PORTS-1:0]  tag_id [RD_LATENCY];

  assign arb_enable = ~rd_stall;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .req       (req_vld),
    .ptr       (rr_ptr),
    .enable    (arb_enable),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ack = grant;

  // Advance the pointer past the accepted client; hold it on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // One-hot mux of the granted client's address and dword enables.
  always_comb begin
    sel_en   = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_en   = req_en[i*EN_W +: EN_W];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Issue stage: register the granted read toward the bank. Idle cycles
  // drive all zeros, the address is deliberately not held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_rd_en     <= '0;
      bank_rd_addr   <= '0;
      rd_port_select <= '0;
    end else begin
      bank_rd_en     <= sel_en;
      bank_rd_addr   <= sel_addr;
      rd_port_select <= SGPR_MAX_PORTS'(grant);
    end
  end

  assign issue_id  = rd_port_select[NUM_PORTS-1:0];
  assign issue_vld = |issue_id;

  // Tag shift register, loaded from the issue stage. A request with all
  // enables clear is still tracked so its client sees a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_vld[0] <= issue_vld;
      tag_id[0]  <= issue_id;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  // Response stage: capture bank data in the cycle the oldest tag lines up
  // with it; the strobe is a one-cycle pulse and the data is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld  <= '0;
      rsp_data <= '0;
    end else begin
      rsp_vld <= tag_vld[RD_LATENCY-1] ? tag_id[RD_LATENCY-1] : '0;
      if (tag_vld[RD_LATENCY-1]) begin
        rsp_data <= bank_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sgpr_rd_port_arbiter.sv
// Bench for sgpr_rd_port_arbiter: two instances (read latency 1 and 3) share
// one stimulus stream. A transaction-level model predicts grants, the issue
// stage and the response stream; a negedge process compares every cycle.
module tb_sgpr_rd_port_arbiter;

  localparam int N    = 10;
  localparam int AW   = 9;
  localparam int DW   = 128;
  localparam int LA   = 1;
  localparam int LB   = 3;
  localparam int MAXC = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_vld      = '0;
  logic [N*AW-1:0] req_addr     = '0;
  logic [N*4-1:0]  req_en       = '0;
  logic            rd_stall     = 1'b0;
  logic [DW-1:0]   bank_rd_data = '0;

  logic [N-1:0]  req_ack_a,  req_ack_b;
  logic [3:0]    bank_rd_en_a, bank_rd_en_b;
  logic [AW-1:0] bank_rd_addr_a, bank_rd_addr_b;
  logic [15:0]   rd_port_select_a, rd_port_select_b;
  logic [N-1:0]  rsp_vld_a, rsp_vld_b;
  logic [DW-1:0] rsp_data_a, rsp_data_b;

  sgpr_rd_port_arbiter #(.NUM_PORTS(N), .RD_LATENCY(LA), .ADDR_W(AW), .DATA_W(DW)) dut_a (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_en(req_en),
    .req_ack(req_ack_a), .rd_stall(rd_stall), .bank_rd_en(bank_rd_en_a),
    .bank_rd_addr(bank_rd_addr_a), .bank_rd_data(bank_rd_data),
    .rd_port_select(rd_port_select_a), .rsp_vld(rsp_vld_a), .rsp_data(rsp_data_a)
  );

  sgpr_rd_port_arbiter #(.NUM_PORTS(N), .RD_LATENCY(LB), .ADDR_W(AW), .DATA_W(DW)) dut_b (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_en(req_en),
    .req_ack(req_ack_b), .rd_stall(rd_stall), .bank_rd_en(bank_rd_en_b),
    .bank_rd_addr(bank_rd_addr_b), .bank_rd_data(bank_rd_data),
    .rd_port_select(rd_port_select_b), .rsp_vld(rsp_vld_b), .rsp_data(rsp_data_b)
  );

  // ---------------- model state ----------------
  typedef struct {
    int         due;
    int         port;
    logic [3:0] en;
  } rsp_t;

  rsp_t exp_q_a[$];
  rsp_t exp_q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_on = 1'b0;

  int         m_ptr   = 0;
  int         m_ack   = -1;
  bit         m_rst   = 1'b0;
  int         iss_port = -1;
  logic [AW-1:0] iss_addr = '0;
  logic [3:0]    iss_en   = '0;
  logic [DW-1:0] held_a = '0, held_b = '0;
  bit            known_a = 1'b1, known_b = 1'b1;
  logic [DW-1:0] bank_h [MAXC];

  bit            pend   [N];
  logic [AW-1:0] p_addr [N];
  logic [3:0]    p_en   [N];

  bit            fix_data = 1'b0;
  logic [DW-1:0] fix_val  = '0;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int p);
    logic [N-1:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  // First requester at or after the pointer, wrapping around.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_ack    = -1;
    m_rst    = 1'b1;
    iss_port = -1;
    exp_q_a.delete();
    exp_q_b.delete();
    held_a  = '0;
    held_b  = '0;
    known_a = 1'b1;
    known_b = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [3:0] e);
    pend[i]   = 1'b1;
    p_addr[i] = a;
    p_en[i]   = e;
  endtask

  // ---------------- driver ----------------
  task automatic apply(input bit r, input bit stall);
    rst      = r;
    rd_stall = stall;
    for (int i = 0; i < N; i++) begin
      req_vld[i]           = pend[i] & ~r;
      req_addr[i*AW +: AW] = p_addr[i];
      req_en[i*4 +: 4]     = p_en[i];
    end
    bank_rd_data = fix_data ? fix_val : {$urandom, $urandom, $urandom, $urandom};
    bank_h[cyc]  = bank_rd_data;
    if (r) begin
      model_reset();
    end else begin
      m_rst = 1'b0;
      m_ack = stall ? -1 : rr_pick(req_vld, m_ptr);
    end
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic assert_rst_now();
    rst     = 1'b1;
    req_vld = '0;
    model_reset();
  endtask

  task automatic tick();
    rsp_t t;
    @(posedge clk);
    if (!m_rst && m_ack >= 0) begin
      t.port = m_ack;
      t.en   = p_en[m_ack];
      t.due  = cyc + LA + 2;
      exp_q_a.push_back(t);
      t.due  = cyc + LB + 2;
      exp_q_b.push_back(t);
      iss_port = m_ack;
      iss_addr = p_addr[m_ack];
      iss_en   = p_en[m_ack];
      m_ptr    = (m_ack + 1) % N;
      pend[m_ack] = 1'b0;
    end else begin
      iss_port = -1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      apply(1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic clients_rand(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        if ($urandom_range(0, 99) < pct) begin
          set_req(i, AW'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
        end
      end else if ($urandom_range(0, 99) < 3) begin
        pend[i] = 1'b0;
      end
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      logic [N-1:0] exp_rv;
      if (m_rst) begin
        chk("rst_ack_a", DW'(req_ack_a), '0);
        chk("rst_en_a", DW'(bank_rd_en_a), '0);
        chk("rst_addr_a", DW'(bank_rd_addr_a), '0);
        chk("rst_sel_a", DW'(rd_port_select_a), '0);
        chk("rst_rsp_vld_a", DW'(rsp_vld_a), '0);
        chk("rst_rsp_data_a", rsp_data_a, '0);
        chk("rst_sel_b", DW'(rd_port_select_b), '0);
        chk("rst_rsp_vld_b", DW'(rsp_vld_b), '0);
        chk("rst_rsp_data_b", rsp_data_b, '0);
      end else begin
        chk("ack_a", DW'(req_ack_a), DW'(oh(m_ack)));
        chk("ack_b", DW'(req_ack_b), DW'(oh(m_ack)));
        chk("bank_en_a", DW'(bank_rd_en_a), (iss_port >= 0) ? DW'(iss_en) : '0);
        chk("bank_addr_a", DW'(bank_rd_addr_a), (iss_port >= 0) ? DW'(iss_addr) : '0);
        chk("sel_a", DW'(rd_port_select_a), DW'(oh(iss_port)));
        chk("bank_en_b", DW'(bank_rd_en_b), (iss_port >= 0) ? DW'(iss_en) : '0);
        chk("bank_addr_b", DW'(bank_rd_addr_b), (iss_port >= 0) ? DW'(iss_addr) : '0);
        chk("sel_b", DW'(rd_port_select_b), DW'(oh(iss_port)));

        exp_rv = '0;
        if (exp_q_a.size() > 0 && exp_q_a[0].due == cyc) begin
          exp_rv = oh(exp_q_a[0].port);
          if (exp_q_a[0].en != 4'd0) begin
            held_a  = bank_h[cyc-1];
            known_a = 1'b1;
          end else begin
            known_a = 1'b0;
          end
          void'(exp_q_a.pop_front());
        end
        chk("rsp_vld_a", DW'(rsp_vld_a), DW'(exp_rv));
        if (known_a) chk("rsp_data_a", rsp_data_a, held_a);

        exp_rv = '0;
        if (exp_q_b.size() > 0 && exp_q_b[0].due == cyc) begin
          exp_rv = oh(exp_q_b[0].port);
          if (exp_q_b[0].en != 4'd0) begin
            held_b  = bank_h[cyc-1];
            known_b = 1'b1;
          end else begin
            known_b = 1'b0;
          end
          void'(exp_q_b.pop_front());
        end
        chk("rsp_vld_b", DW'(rsp_vld_b), DW'(exp_rv));
        if (known_b) chk("rsp_data_b", rsp_data_b, held_b);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i]   = 1'b0;
      p_addr[i] = '0;
      p_en[i]   = '0;
    end

    @(posedge clk);
    #1;
    apply(1'b1, 1'b0);
    model_on = 1'b1;
    #1;
    chk("reset_bank_en", DW'(bank_rd_en_a), DW'(4'h0));
    chk("reset_rsp_vld", DW'(rsp_vld_a), DW'(10'h000));
    tick();
    apply(1'b1, 1'b0);
    tick();

    // Single read on port 3, bank data fixed to an A5 pattern.
    fix_data = 1'b1;
    fix_val  = {16{8'hA5}};
    set_req(3, 9'h012, 4'hF);
    apply(1'b0, 1'b0); #1;
    chk("single_ack", DW'(req_ack_a), DW'(10'h008));
    tick();
    apply(1'b0, 1'b0); #1;
    chk("single_addr", DW'(bank_rd_addr_a), DW'(9'h012));
    chk("single_sel", DW'(rd_port_select_a), DW'(16'h0008));
    chk("single_en", DW'(bank_rd_en_a), DW'(4'hF));
    tick();
    apply(1'b0, 1'b0);
    tick();
    apply(1'b0, 1'b0); #1;
    chk("single_rsp_vld", DW'(rsp_vld_a), DW'(10'h008));
    chk("single_rsp_data", rsp_data_a, {16{8'hA5}});
    tick();
    fix_data = 1'b0;

    // Pointer to 5, then ports 2 and 7 together: 7 first, then 2.
    set_req(4, 9'h040, 4'h3);
    apply(1'b0, 1'b0); #1;
    chk("ptr_setup_ack", DW'(req_ack_a), DW'(10'h010));
    tick();
    set_req(2, 9'h022, 4'h1);
    set_req(7, 9'h077, 4'h8);
    apply(1'b0, 1'b0); #1;
    chk("rr_first_ack", DW'(req_ack_a), DW'(10'h080));
    tick();
    apply(1'b0, 1'b0); #1;
    chk("rr_second_ack", DW'(req_ack_a), DW'(10'h004));
    tick();
    idle(5);

    // Stall with one read in flight and SALU waiting.
    set_req(0, 9'h100, 4'hF);
    apply(1'b0, 1'b0); #1;
    chk("stall_pre_ack", DW'(req_ack_a), DW'(10'h001));
    tick();
    set_req(9, 9'h1FF, 4'hC);
    apply(1'b0, 1'b1); #1;
    chk("stall_ack0", DW'(req_ack_a), DW'(10'h000));
    tick();
    apply(1'b0, 1'b1); #1;
    chk("stall_ack1", DW'(req_ack_a), DW'(10'h000));
    tick();
    apply(1'b0, 1'b1); #1;
    chk("stall_ack2", DW'(req_ack_a), DW'(10'h000));
    chk("stall_inflight_rsp", DW'(rsp_vld_a), DW'(10'h001));
    tick();
    apply(1'b0, 1'b0); #1;
    chk("stall_release_ack", DW'(req_ack_a), DW'(10'h200));
    tick();
    idle(6);

    // Reset the cycle after issue: outputs clear at once, no response later.
    set_req(2, 9'h0AB, 4'hF);
    apply(1'b0, 1'b0); #1;
    chk("prerst_ack", DW'(req_ack_a), DW'(10'h004));
    tick();
    apply(1'b0, 1'b0); #1;
    chk("prerst_sel", DW'(rd_port_select_a), DW'(16'h0004));
    assert_rst_now(); #1;
    chk("async_rst_en", DW'(bank_rd_en_a), DW'(4'h0));
    chk("async_rst_addr", DW'(bank_rd_addr_a), DW'(9'h000));
    chk("async_rst_sel", DW'(rd_port_select_a), DW'(16'h0000));
    tick();
    apply(1'b1, 1'b0);
    tick();
    idle(5);

    // All ten clients requesting continuously from the reset pointer.
    for (int k = 0; k < 11; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) set_req(i, AW'($urandom_range(0, 511)), 4'($urandom_range(1, 15)));
      end
      apply(1'b0, 1'b0); #1;
      chk("all10_ack", DW'(req_ack_a), DW'(oh(k % N)));
      tick();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    idle(8);

    // Latency-3 instance: port 1 with a sparse enable mask.
    set_req(1, 9'h155, 4'b0101);
    apply(1'b0, 1'b0); #1;
    chk("l3_ack", DW'(req_ack_b), DW'(10'h002));
    tick();
    apply(1'b0, 1'b0); #1;
    chk("l3_bank_en", DW'(bank_rd_en_b), DW'(4'b0101));
    tick();
    idle(3);
    apply(1'b0, 1'b0); #1;
    chk("l3_rsp_vld", DW'(rsp_vld_b), DW'(10'h002));
    tick();
    idle(4);

    // Randomized traffic with stalls, drops and occasional resets.
    for (int c = 0; c < 800; c++) begin
      clients_rand(40);
      apply(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 15));
      tick();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
